// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Inter-stage pipeline register (payload, PC, valid, write-enables)
//             with stall/bubble/flush handling and saturating stall and bubble
//             performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int              PAYLOAD_W       = 128,
    parameter int              NUM_WE          = 4,
    parameter int              PC_W            = 32,
    parameter int              CLEAR_ON_BUBBLE = 1,
    parameter int              CNT_W           = 16,
    parameter logic [PC_W-1:0] RST_PC          = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_WE-1:0]    in_we,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 stall_cur,
    input  logic                 stall_next,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [NUM_WE-1:0]    out_we,
    output logic [PC_W-1:0]      out_pc,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Stage state and its next-state values
    logic                 valid_q,   valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [NUM_WE-1:0]    we_q,      we_d;
    logic [PC_W-1:0]      pc_q,      pc_d;
    logic [CNT_W-1:0]     scnt_q,    scnt_d;
    logic [CNT_W-1:0]     bcnt_q,    bcnt_d;

    // Operation decode; flush outranks every stall combination
    logic w_kill;
    logic w_bubble;
    logic w_load;

    assign w_kill   = flush;
    assign w_bubble = !flush && stall_cur && !stall_next;
    assign w_load   = !flush && !stall_cur;

    // Next-state for the carried contents; HOLD is the default (keep values)
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        we_d      = we_q;
        pc_d      = pc_q;
        if (w_kill || w_bubble) begin
            valid_d = 1'b0;
            we_d    = '0;
            pc_d    = RST_PC;
            if (CLEAR_ON_BUBBLE != 0) begin
                payload_d = '0;
            end
        end else if (w_load) begin
            valid_d   = in_valid;
            payload_d = in_payload;
            pc_d      = in_pc;
            // Write-enables of a non-instruction must never reach the consumer
            we_d      = in_valid ? in_we : '0;
        end
    end

    // Next-state for the saturating counters; clear beats increment
    always_comb begin
        scnt_d = scnt_q;
        bcnt_d = bcnt_q;
        if (cnt_clr) begin
            scnt_d = '0;
            bcnt_d = '0;
        end else begin
            if (stall_cur && (scnt_q != c_CNT_MAX)) begin
                scnt_d = scnt_q + c_CNT_ONE;
            end
            if (w_bubble && (bcnt_q != c_CNT_MAX)) begin
                bcnt_d = bcnt_q + c_CNT_ONE;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            we_q      <= '0;
            pc_q      <= RST_PC;
            scnt_q    <= '0;
            bcnt_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            we_q      <= we_d;
            pc_q      <= pc_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_we      = we_q;
    assign out_pc      = pc_q;
    assign stall_cnt   = scnt_q;
    assign bubble_cnt  = bcnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the CPU datapath (ID/EX, EX/MEM, MEM/WB). It carries a payload bus, a PC, a valid bit and a vector of write-enable channels (regfile, hi/lo, cp0 and others). Behaviour on load, hold and bubble follows the 6-bit stall vector. It adds a flush input, enable gating by valid, and saturating stall and bubble performance counters.

Parameters:
PAYLOAD_W, 128, width of the opaque payload bus (wd, wdata, hi, lo, aluop, mem_addr, reg2, cp0 data and so on, concatenated by the instantiating stage)
NUM_WE, 4, number of write-enable channels
PC_W, 32, PC width
CLEAR_ON_BUBBLE, 1, 1 means the payload is zeroed on bubble or flush; 0 means the payload is retained
CNT_W, 16, width of each performance counter
RST_PC, 32'h0, PC value loaded on reset, bubble and flush

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream stage holds a real instruction
in_payload  input  PAYLOAD_W  upstream payload
in_we  input  NUM_WE  upstream write-enables
in_pc  input  PC_W  upstream PC
stall_cur  input  1  the upstream stage is stopped (stall[k])
stall_next  input  1  this stage's consumer is stopped (stall[k+1])
flush  input  1  exception or eret flush; kills the stage contents
cnt_clr  input  1  synchronous clear of both counters
out_valid  output  1  registered valid
out_payload  output  PAYLOAD_W  registered payload
out_we  output  NUM_WE  registered write-enables
out_pc  output  PC_W  registered PC
stall_cnt  output  CNT_W  cycles with stall_cur=1
bubble_cnt  output  CNT_W  bubbles inserted

Behaviour:
- Reset: rst=0 acts immediately, with no clock required.
  - Outputs go to: out_valid=0, out_we=0, out_payload=0, out_pc=RST_PC, stall_cnt=0, bubble_cnt=0.
  - If reset is asserted mid-stall, all state, including held data, is discarded.
- Update priority at each rising clk while rst=1 (highest first):
  1. flush=1: KILL.
  2. stall_cur=1 and stall_next=0: BUBBLE.
  3. stall_cur=0: LOAD.
  4. stall_cur=1 and stall_next=1: HOLD.
- KILL and BUBBLE:
  - out_valid=0, out_we=0 (every channel), out_pc=RST_PC.
  - out_payload=0 if CLEAR_ON_BUBBLE=1, otherwise unchanged.
- LOAD:
  - out_valid<=in_valid, out_payload<=in_payload, out_pc<=in_pc.
  - out_we<=in_we masked by in_valid (all zero when in_valid=0).
- HOLD: every output register keeps its value.
- Invariant: out_we is never nonzero while out_valid=0.
- Latency: exactly one cycle from input to output on LOAD. No combinational path from any input to any output.
- Flush overrides stall: flush with stall_cur=1 and stall_next=1 still kills the stage.
- stall_cnt:
  - +1 on each clock edge with stall_cur=1, including during flush.
  - Saturates at 2^CNT_W-1 and does not wrap.
- bubble_cnt:
  - +1 on each BUBBLE edge only; KILL does not count.
  - Saturates at 2^CNT_W-1.
- cnt_clr=1 zeroes both counters on that edge. Clear wins over a simultaneous increment.
- Unused channels: NUM_WE=1 must be legal. PAYLOAD_W has a minimum of 1.

Test Plan:
- Reset, then LOAD:
  - Stimulus: rst low for 3 cycles, release; then in_valid=1, in_we=4'b0101, in_pc=32'h1000, payload=128'hA5 with stall_cur=0.
  - Response: one cycle later out_valid=1, out_we=4'b0101, out_pc=32'h1000, out_payload=128'hA5.
- Bubble:
  - Stimulus: with loaded contents, set stall_cur=1, stall_next=0 for 1 cycle.
  - Response: out_valid=0, out_we=0, out_pc=0, out_payload=0, bubble_cnt=1, stall_cnt=1.
  - Repeat with CLEAR_ON_BUBBLE=0: payload stays 128'hA5.
- Hold:
  - Stimulus: stall_cur=1, stall_next=1 for 5 cycles while the inputs change.
  - Response: outputs frozen at the loaded values, stall_cnt=5, bubble_cnt=0.
- Flush over stall and valid masking:
  - Stimulus: flush=1 during HOLD.
  - Response: out_valid=0, out_we=0 on the next edge, bubble_cnt unchanged.
  - Stimulus: LOAD with in_valid=0, in_we=4'b1111.
  - Response: out_we=0.
- Counter saturation and clear:
  - Stimulus: CNT_W=4, stall_cur=1 for 20 cycles.
  - Response: stall_cnt=15 and stays at 15.
  - Stimulus: cnt_clr=1 with stall_cur=1.
  - Response: stall_cnt=0 on that edge.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst=0 between clock edges during HOLD.
  - Response: all outputs reach their reset values before the next rising edge.
